// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
//   tFetchState : sequencer FSM states
//   tFetchEntry : one queued instruction word with the PC it was fetched from
//   cInstBytes  : PC increment per fetched word
package fetch_sequencer_pkg;

   typedef enum logic [1:0] {
      sIdle  = 2'd0,
      sFetch = 2'd1,
      sFlush = 2'd2
   } tFetchState;

   localparam int unsigned cInstBytes = 4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } tFetchEntry;

endpackage

// File: rtl/fetch_sequencer_queue.sv
// Small synchronous FIFO used for the instruction queue and for the
// request-PC shadow queue of the fetch sequencer.
//   iClk, iRst  : clock, asynchronous active-low reset
//   iPush/iEntry: write one entry (caller never pushes when full)
//   iPop        : drop the head entry (caller never pops when empty)
//   iFlush      : empty the queue; wins over push/pop in the same cycle
//   oCount      : number of stored entries
//   oHead       : oldest stored entry
module fetch_sequencer_queue
   import fetch_sequencer_pkg::*;
#(
   parameter int  cDepth = 2,
   parameter type tEntry = tFetchEntry,
   localparam int cCntW  = $clog2(cDepth + 1)
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iPush,
   input  tEntry            iEntry,
   input  logic             iPop,
   input  logic             iFlush,
   output logic [cCntW-1:0] oCount,
   output tEntry            oHead
);

   localparam int cPtrW = (cDepth > 1) ? $clog2(cDepth) : 1;

   tEntry             mem_q [cDepth];
   logic [cPtrW-1:0]  wr_q, rd_q;
   logic [cCntW-1:0]  count_q;

   function automatic logic [cPtrW-1:0] ptr_inc(input logic [cPtrW-1:0] p);
      return (p == cPtrW'(cDepth - 1)) ? '0 : p + cPtrW'(1);
   endfunction

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         for (int i = 0; i < cDepth; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (iFlush) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (iPush) begin
            mem_q[wr_q] <= iEntry;
            wr_q        <= ptr_inc(wr_q);
         end
         if (iPop) rd_q <= ptr_inc(rd_q);
         count_q <= count_q + cCntW'(iPush) - cCntW'(iPop);
      end
   end

   assign oCount = count_q;
   assign oHead  = mem_q[rd_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues in-order word reads to
// instruction memory, queues returned words and hands them to the decoder.
//   iClk, iRst                 : clock, asynchronous active-low reset
//   oMemReq/oMemAddr/iMemGnt   : memory request port
//   iMemRdv/iMemRdata          : in-order memory responses
//   iRedirect/iRedirectPc      : control-flow change (highest priority)
//   iStall                     : decoder back-pressure
//   oInst/oInstPc/oInstDv      : instruction to the decoder
//
//   state  | meaning
//   sIdle  | just out of reset, no requests yet
//   sFetch | issuing requests while credit is available
//   sFlush | draining responses orphaned by a redirect, no requests
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] cResetPc = 32'h0000_0000,
   parameter int          cDepth   = 2
) (
   input  logic        iClk,
   input  logic        iRst,
   output logic        oMemReq,
   output logic [31:0] oMemAddr,
   input  logic        iMemGnt,
   input  logic        iMemRdv,
   input  logic [31:0] iMemRdata,
   input  logic        iRedirect,
   input  logic [31:0] iRedirectPc,
   input  logic        iStall,
   output logic [31:0] oInst,
   output logic [31:0] oInstPc,
   output logic        oInstDv
);

   localparam int              cCntW   = $clog2(cDepth + 1);
   localparam logic [cCntW:0]  cDepthW = (cCntW + 1)'(cDepth);

   tFetchState        state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [cCntW-1:0]  discard_q, discard_d;
   logic [cCntW-1:0]  inflight, count;
   logic [cCntW:0]    credit_used, owed;
   logic [31:0]       shadow_pc;
   tFetchEntry        head, push_entry;
   logic              mem_req, grant, pop_inst, rdv_tracked;

   // The shadow queue's occupancy is exactly the number of tracked requests
   // in flight: pushed on grant, popped on a tracked response, flushed on
   // redirect (orphaned responses are then counted by discard instead).
   fetch_sequencer_queue #(
      .cDepth (cDepth),
      .tEntry (logic [31:0])
   ) u_pc_shadow (
      .iClk   (iClk),
      .iRst   (iRst),
      .iPush  (grant),
      .iEntry (pc_q),
      .iPop   (rdv_tracked),
      .iFlush (iRedirect),
      .oCount (inflight),
      .oHead  (shadow_pc)
   );

   fetch_sequencer_queue #(
      .cDepth (cDepth),
      .tEntry (tFetchEntry)
   ) u_inst_queue (
      .iClk   (iClk),
      .iRst   (iRst),
      .iPush  (rdv_tracked),
      .iEntry (push_entry),
      .iPop   (pop_inst),
      .iFlush (iRedirect),
      .oCount (count),
      .oHead  (head)
   );

   always_comb begin
      pop_inst        = (count != '0) && !iStall;
      // The same-cycle pop frees a slot, so a zero-wait memory with a
      // single-cycle response keeps one fetch per cycle going.
      credit_used     = {1'b0, inflight} + {1'b0, count} - (cCntW + 1)'(pop_inst);
      owed            = {1'b0, discard_q} + {1'b0, inflight};
      rdv_tracked     = iMemRdv && !iRedirect && (discard_q == '0) && (inflight != '0);
      grant           = mem_req && iMemGnt;
      push_entry.inst = iMemRdata;
      push_entry.pc   = shadow_pc;

      discard_d = discard_q;
      if (iRedirect) begin
         // Everything still owed by memory becomes discard; a response
         // arriving in the redirect cycle is dropped and settles one of them.
         if (iMemRdv && (owed != '0)) discard_d = cCntW'(owed - (cCntW + 1)'(1));
         else                         discard_d = cCntW'(owed);
      end else if (iMemRdv && (discard_q != '0)) begin
         discard_d = discard_q - cCntW'(1);
      end

      pc_d = pc_q;
      if (iRedirect)  pc_d = {iRedirectPc[31:2], 2'b00};
      else if (grant) pc_d = pc_q + 32'(cInstBytes);
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         pc_q      <= cResetPc;
         discard_q <= '0;
      end else begin
         pc_q      <= pc_d;
         discard_q <= discard_d;
      end
   end

   // FSM: state register
   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) state_q <= sIdle;
      else       state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      if (iRedirect) begin
         state_d = (discard_d != '0) ? sFlush : sFetch;
      end else begin
         case (state_q)
            sIdle:   state_d = sFetch;
            sFetch:  state_d = sFetch;
            sFlush:  state_d = (discard_d == '0) ? sFetch : sFlush;
            default: state_d = sIdle;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      mem_req  = (state_q == sFetch) && !iRedirect && (credit_used < cDepthW);
      oMemReq  = mem_req;
      oMemAddr = pc_q;
      oInstDv  = (count != '0);
      oInst    = head.inst;
      oInstPc  = head.pc;
   end

   a_inflight_bound: assert property (@(posedge iClk) disable iff (!iRst)
      inflight <= cCntW'(cDepth));
   a_count_bound: assert property (@(posedge iClk) disable iff (!iRst)
      count <= cCntW'(cDepth));
   a_discard_bound: assert property (@(posedge iClk) disable iff (!iRst)
      discard_q <= cCntW'(cDepth));
   a_unexpected_rdv: assert property (@(posedge iClk) disable iff (!iRst)
      iMemRdv |-> ((inflight != '0) || (discard_q != '0)));

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        iRst;
   logic        oMemReq;
   logic [31:0] oMemAddr;
   logic        iMemGnt;
   logic        iMemRdv;
   logic [31:0] iMemRdata;
   logic        iRedirect;
   logic [31:0] iRedirectPc;
   logic        iStall;
   logic [31:0] oInst;
   logic [31:0] oInstPc;
   logic        oInstDv;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } resp_t;

   resp_t mq[$];
   int    cyc;
   int    lat;
   logic  gnt_en;

   logic        s_req, s_dv;
   logic [31:0] s_addr, s_inst, s_pc;

   always #5 clk = ~clk;

   fetch_sequencer #(
      .cResetPc (32'h0000_0000),
      .cDepth   (2)
   ) dut (
      .iClk        (clk),
      .iRst        (iRst),
      .oMemReq     (oMemReq),
      .oMemAddr    (oMemAddr),
      .iMemGnt     (iMemGnt),
      .iMemRdv     (iMemRdv),
      .iMemRdata   (iMemRdata),
      .iRedirect   (iRedirect),
      .iRedirectPc (iRedirectPc),
      .iStall      (iStall),
      .oInst       (oInst),
      .oInstPc     (oInstPc),
      .oInstDv     (oInstDv)
   );

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'hC0DE_5A00;
   endfunction

   // One clock cycle, entered and left at the falling edge. Memory model:
   // every granted request returns its word exactly lat cycles later.
   task automatic step();
      iMemRdv   = 1'b0;
      iMemRdata = '0;
      if (mq.size() > 0 && mq[0].due == cyc) begin
         iMemRdv   = 1'b1;
         iMemRdata = mem_data(mq[0].addr);
         mq.delete(0);
      end
      iMemGnt = gnt_en;
      #1;
      s_req  = oMemReq;
      s_addr = oMemAddr;
      s_dv   = oInstDv;
      s_inst = oInst;
      s_pc   = oInstPc;
      if (s_req && gnt_en) mq.push_back('{addr: s_addr, due: cyc + lat});
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset();
      iRst        = 1'b0;
      iMemGnt     = 1'b0;
      iMemRdv     = 1'b0;
      iMemRdata   = '0;
      iRedirect   = 1'b0;
      iRedirectPc = '0;
      iStall      = 1'b0;
      gnt_en      = 1'b1;
      lat         = 1;
      mq.delete();
      repeat (2) @(negedge clk);
      iRst = 1'b1;
      cyc  = 0;
   endtask

   task automatic test_reset();
      iRst = 1'b0;
      iMemGnt = 1'b0; iMemRdv = 1'b0; iMemRdata = '0;
      iRedirect = 1'b0; iRedirectPc = '0; iStall = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (oMemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", oMemReq); end
      checks++;
      if (oMemAddr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h want 00000000", oMemAddr); end
      checks++;
      if (oInstDv !== 1'b0) begin errors++; $display("FAIL reset_dv: got %b want 0", oInstDv); end
      checks++;
      if (oInst !== 32'h0 || oInstPc !== 32'h0) begin
         errors++; $display("FAIL reset_inst: got inst %h pc %h want 0/0", oInst, oInstPc);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      for (int k = 0; k < 10; k++) begin
         step();
         checks++;
         if (s_req !== (k >= 1)) begin
            errors++; $display("FAIL seq_req step %0d: got %b want %b", k, s_req, (k >= 1));
         end
         if (k >= 1) begin
            checks++;
            if (s_addr !== 32'(4 * (k - 1))) begin
               errors++; $display("FAIL seq_addr step %0d: got %h want %h", k, s_addr, 32'(4 * (k - 1)));
            end
         end
         checks++;
         if (s_dv !== (k >= 3)) begin
            errors++; $display("FAIL seq_dv step %0d: got %b want %b", k, s_dv, (k >= 3));
         end
         if (k >= 3) begin
            checks++;
            if (s_pc !== 32'(4 * (k - 3)) || s_inst !== mem_data(32'(4 * (k - 3)))) begin
               errors++; $display("FAIL seq_inst step %0d: got pc %h inst %h want pc %h inst %h",
                                  k, s_pc, s_inst, 32'(4 * (k - 3)), mem_data(32'(4 * (k - 3))));
            end
         end
      end
   endtask

   task automatic test_stall();
      logic        exp_req  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] exp_addr [9] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h0, 32'h8, 32'hC, 32'h10, 32'h14};
      logic [31:0] exp_pc   [9] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
      do_reset();
      for (int k = 0; k < 9; k++) begin
         iStall = (k <= 4);
         step();
         checks++;
         if (s_req !== exp_req[k]) begin
            errors++; $display("FAIL stall_req step %0d: got %b want %b", k, s_req, exp_req[k]);
         end
         if (exp_req[k]) begin
            checks++;
            if (s_addr !== exp_addr[k]) begin
               errors++; $display("FAIL stall_addr step %0d: got %h want %h", k, s_addr, exp_addr[k]);
            end
         end
         checks++;
         if (s_dv !== (k >= 3)) begin
            errors++; $display("FAIL stall_dv step %0d: got %b want %b", k, s_dv, (k >= 3));
         end
         if (k >= 3) begin
            checks++;
            if (s_pc !== exp_pc[k] || s_inst !== mem_data(exp_pc[k])) begin
               errors++; $display("FAIL stall_inst step %0d: got pc %h inst %h want pc %h",
                                  k, s_pc, s_inst, exp_pc[k]);
            end
         end
      end
      iStall = 1'b0;
   endtask

   task automatic test_redirect_flush();
      do_reset();
      lat = 3;
      for (int k = 0; k < 12; k++) begin
         iRedirect   = (k == 3);
         iRedirectPc = 32'h0000_0100;
         step();
         if (k >= 3 && k <= 5) begin
            checks++;
            if (s_req !== 1'b0) begin
               errors++; $display("FAIL redir_req_off step %0d: got %b want 0", k, s_req);
            end
         end
         if (k == 6) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h0000_0100) begin
               errors++; $display("FAIL redir_new_addr: got req %b addr %h want 1 00000100", s_req, s_addr);
            end
         end
         if (k >= 4 && k <= 9) begin
            checks++;
            if (s_dv !== 1'b0) begin
               errors++; $display("FAIL redir_stale_dv step %0d: got %b pc %h want 0", k, s_dv, s_pc);
            end
         end
         if (k == 10 || k == 11) begin
            checks++;
            if (s_dv !== 1'b1 || s_pc !== 32'(32'h100 + 4 * (k - 10)) ||
                s_inst !== mem_data(32'(32'h100 + 4 * (k - 10)))) begin
               errors++; $display("FAIL redir_inst step %0d: got dv %b pc %h inst %h want pc %h",
                                  k, s_dv, s_pc, s_inst, 32'(32'h100 + 4 * (k - 10)));
            end
         end
      end
      iRedirect = 1'b0;
   endtask

   task automatic test_redirect_with_rdv();
      do_reset();
      lat = 2;
      for (int k = 0; k < 7; k++) begin
         gnt_en    = (k != 2);
         lat       = (k >= 4) ? 1 : 2;
         iRedirect = (k == 3);
         iRedirectPc = 32'h0000_0200;
         step();
         if (k == 3) begin
            checks++;
            if (s_req !== 1'b0) begin
               errors++; $display("FAIL rdvredir_req_off: got %b want 0", s_req);
            end
         end
         if (k == 4) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h0000_0200) begin
               errors++; $display("FAIL rdvredir_resume: got req %b addr %h want 1 00000200", s_req, s_addr);
            end
         end
         if (k == 4 || k == 5) begin
            checks++;
            if (s_dv !== 1'b0) begin
               errors++; $display("FAIL rdvredir_dropped step %0d: got dv %b pc %h want 0", k, s_dv, s_pc);
            end
         end
         if (k == 6) begin
            checks++;
            if (s_dv !== 1'b1 || s_pc !== 32'h0000_0200 || s_inst !== mem_data(32'h200)) begin
               errors++; $display("FAIL rdvredir_inst: got dv %b pc %h inst %h want pc 00000200", s_dv, s_pc, s_inst);
            end
         end
      end
      iRedirect = 1'b0;
      gnt_en    = 1'b1;
   endtask

   task automatic test_pc_wrap();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         iRedirect   = (k == 0);
         iRedirectPc = 32'hFFFF_FFFE;
         step();
         if (k == 1) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
               errors++; $display("FAIL wrap_align: got req %b addr %h want 1 fffffffc", s_req, s_addr);
            end
         end
         if (k == 2) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h0000_0000) begin
               errors++; $display("FAIL wrap_next: got req %b addr %h want 1 00000000", s_req, s_addr);
            end
         end
         if (k == 3) begin
            checks++;
            if (s_dv !== 1'b1 || s_pc !== 32'hFFFF_FFFC) begin
               errors++; $display("FAIL wrap_inst0: got dv %b pc %h want 1 fffffffc", s_dv, s_pc);
            end
         end
         if (k == 4) begin
            checks++;
            if (s_dv !== 1'b1 || s_pc !== 32'h0000_0000) begin
               errors++; $display("FAIL wrap_inst1: got dv %b pc %h want 1 00000000", s_dv, s_pc);
            end
         end
      end
      iRedirect = 1'b0;
   endtask

   task automatic test_reset_midrun();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         iStall = 1'b1;
         step();
      end
      checks++;
      if (s_dv !== 1'b1 || s_pc !== 32'h0) begin
         errors++; $display("FAIL midrst_full: got dv %b pc %h want 1 00000000", s_dv, s_pc);
      end
      #2;
      iRst    = 1'b0;
      iMemRdv = 1'b0;
      #1;
      checks++;
      if (oMemReq !== 1'b0 || oInstDv !== 1'b0) begin
         errors++; $display("FAIL midrst_async: got req %b dv %b want 0 0", oMemReq, oInstDv);
      end
      checks++;
      if (oMemAddr !== 32'h0 || oInst !== 32'h0 || oInstPc !== 32'h0) begin
         errors++; $display("FAIL midrst_values: got addr %h inst %h pc %h want 0", oMemAddr, oInst, oInstPc);
      end
      do_reset();
      for (int k = 0; k < 4; k++) begin
         step();
         if (k == 1) begin
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h0) begin
               errors++; $display("FAIL midrst_restart: got req %b addr %h want 1 00000000", s_req, s_addr);
            end
         end
         if (k == 3) begin
            checks++;
            if (s_dv !== 1'b1 || s_pc !== 32'h0 || s_inst !== mem_data(32'h0)) begin
               errors++; $display("FAIL midrst_first_inst: got dv %b pc %h inst %h want pc 0", s_dv, s_pc, s_inst);
            end
         end
      end
   endtask

   initial begin
      iRst = 1'b0;
      cyc = 0; lat = 1; gnt_en = 1'b1;
      test_reset();
      test_sequential();
      test_stall();
      test_redirect_flush();
      test_redirect_with_rdv();
      test_pc_wrap();
      test_reset_midrun();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
